// File: rtl/dds_pkg.sv
// Shared types and constants for the multi-voice DDS bank: wave select,
// register map, control bit positions, LFSR parameters and sequencer states.
package dds_pkg;

  typedef enum logic [2:0] {
    WAVE_SAW     = 3'd0,
    WAVE_ISAW    = 3'd1,
    WAVE_SQUARE  = 3'd2,
    WAVE_TRI     = 3'd3,
    WAVE_PULSE   = 3'd4,
    WAVE_NOISE   = 3'd5,
    WAVE_OFF     = 3'd6,
    WAVE_OFF_ALT = 3'd7
  } wave_e;

  localparam logic [1:0] REG_TUNE_LO = 2'd0;
  localparam logic [1:0] REG_TUNE_HI = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_DUTY    = 2'd3;

  localparam int unsigned CTRL_EN_BIT   = 3;
  localparam int unsigned CTRL_SYNC_BIT = 4;
  localparam int unsigned CTRL_PRST_BIT = 7;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Only the architecturally visible ctrl bits are stored; reserved bits are dropped.
  typedef struct packed {
    logic  prst;
    logic  sync;
    logic  en;
    wave_e wave;
  } ctrl_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dds_wave_gen.sv
// Combinational waveform generator shared by all voices through time-multiplexing.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int unsigned WAVE_W = 12
) (
  input  logic [WAVE_W-1:0] phase,
  input  logic [7:0]        phase_top8,
  input  wave_e             wave_sel,
  input  logic [7:0]        duty,
  input  logic [WAVE_W-1:0] noise,
  output logic [WAVE_W-1:0] sample
);

  logic              msb;
  logic [WAVE_W-1:0] tri_up;

  assign msb    = phase[WAVE_W-1];
  assign tri_up = {phase[WAVE_W-2:0], 1'b0};

  always_comb begin
    sample = '0;
    case (wave_sel)
      WAVE_SAW:    sample = phase;
      WAVE_ISAW:   sample = ~phase;
      WAVE_SQUARE: sample = msb ? '0 : '1;
      WAVE_TRI:    sample = msb ? ~tri_up : tri_up;
      WAVE_PULSE:  sample = (phase_top8 < duty) ? '1 : '0;
      WAVE_NOISE:  sample = noise;
      default:     sample = '0;
    endcase
  end

endmodule

// File: rtl/dds_voice_bank.sv
// Multi-voice DDS bank: register file, per-sample voice sequencer and mixer.
// Optional hard sync between adjacent voices is enabled by DDS_HARD_SYNC_EN.
module dds_voice_bank
  import dds_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned WAVE_W     = 12,
  parameter int unsigned SAMPLE_DIV = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [$clog2(NUM_VOICES)+1:0]   wr_addr,
  input  logic [7:0]                      wr_data,
  input  logic                            mix_mode,
  input  logic [$clog2(NUM_VOICES)-1:0]   out_sel,
  output logic [WAVE_W-1:0]               out_sample,
  output logic                            out_valid
);

  localparam int unsigned VW    = $clog2(NUM_VOICES);
  localparam int unsigned SUM_W = WAVE_W + VW;
  localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

  logic [ACC_W-1:0]  acc_q [NUM_VOICES];
  logic [ACC_W-1:0]  acc_d [NUM_VOICES];
  logic [ACC_W-1:0]  tune_q [NUM_VOICES];
  logic [ACC_W-1:0]  tune_d [NUM_VOICES];
  logic [7:0]        shadow_q [NUM_VOICES];
  logic [7:0]        shadow_d [NUM_VOICES];
  ctrl_t             ctrl_q [NUM_VOICES];
  ctrl_t             ctrl_d [NUM_VOICES];
  logic [7:0]        duty_q [NUM_VOICES];
  logic [7:0]        duty_d [NUM_VOICES];
  logic [WAVE_W-1:0] cap_q [NUM_VOICES];
  logic [WAVE_W-1:0] cap_d [NUM_VOICES];

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  seq_state_e        state_q, state_d;
  logic [VW-1:0]     vidx_q, vidx_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [WAVE_W-1:0] out_sample_q, out_sample_d;
  logic              out_valid_q, out_valid_d;

  logic [ACC_W-1:0]  cur_acc;
  ctrl_t             cur_ctrl;
  logic [WAVE_W-1:0] wave;
  logic              wrap;
  logic              sync_hit;
  logic [VW-1:0]     wr_voice;
  logic [1:0]        wr_reg;

  assign cur_acc  = acc_q[vidx_q];
  assign cur_ctrl = ctrl_q[vidx_q];
  assign wrap     = (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
  assign wr_voice = wr_addr[VW+1:2];
  assign wr_reg   = wr_addr[1:0];

  dds_wave_gen #(
    .WAVE_W(WAVE_W)
  ) u_wave_gen (
    .phase      (cur_acc[ACC_W-1 -: WAVE_W]),
    .phase_top8 (cur_acc[ACC_W-1 -: 8]),
    .wave_sel   (cur_ctrl.wave),
    .duty       (duty_q[vidx_q]),
    .noise      (lfsr_q[15 -: WAVE_W]),
    .sample     (wave)
  );

`ifdef DDS_HARD_SYNC_EN
  logic             carry_q, carry_d;
  logic [ACC_W:0]   inc_full;

  assign inc_full = {1'b0, cur_acc} + {1'b0, tune_q[vidx_q]};
  assign sync_hit = (vidx_q != '0) && cur_ctrl.sync && carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  always_comb begin
    carry_d = carry_q;
    if (wrap) begin
      carry_d = 1'b0;
    end else if (state_q == RUN) begin
      carry_d = !cur_ctrl.prst && !sync_hit && cur_ctrl.en && inc_full[ACC_W];
    end
  end
`else
  assign sync_hit = 1'b0;
`endif

  always_comb begin
    acc_d        = acc_q;
    tune_d       = tune_q;
    shadow_d     = shadow_q;
    ctrl_d       = ctrl_q;
    duty_d       = duty_q;
    cap_d        = cap_q;
    state_d      = state_q;
    vidx_d       = vidx_q;
    sum_d        = sum_q;
    lfsr_d       = lfsr_q;
    out_sample_d = out_sample_q;
    out_valid_d  = 1'b0;
    div_cnt_d    = wrap ? '0 : div_cnt_q + 1'b1;

    case (state_q)
      RUN: begin
        sum_d         = sum_q + (cur_ctrl.en ? SUM_W'(wave) : '0);
        cap_d[vidx_q] = wave;
        if (cur_ctrl.prst || sync_hit) begin
          acc_d[vidx_q] = '0;
        end else if (cur_ctrl.en) begin
          acc_d[vidx_q] = cur_acc + tune_q[vidx_q];
        end
        ctrl_d[vidx_q].prst = 1'b0;
        if (vidx_q == VW'(NUM_VOICES - 1)) begin
          state_d = DONE;
        end else begin
          vidx_d = vidx_q + 1'b1;
        end
      end
      DONE: begin
        out_sample_d = mix_mode ? sum_q[VW +: WAVE_W] : cap_q[out_sel];
        out_valid_d  = 1'b1;
        state_d      = IDLE;
      end
      default: ;
    endcase

    // SAMPLE_DIV >= NUM_VOICES+2 guarantees the sequencer is idle on every wrap.
    if (wrap) begin
      state_d = RUN;
      vidx_d  = '0;
      sum_d   = '0;
      lfsr_d  = lfsr_next(lfsr_q);
    end

    // Applied after sequencing so a same-cycle write wins and the strobe clear cannot drop it.
    if (wr_en) begin
      case (wr_reg)
        REG_TUNE_LO: shadow_d[wr_voice] = wr_data;
        REG_TUNE_HI: tune_d[wr_voice]   = ACC_W'({wr_data, shadow_q[wr_voice]});
        REG_CTRL: begin
          ctrl_d[wr_voice].prst = wr_data[CTRL_PRST_BIT];
          ctrl_d[wr_voice].sync = wr_data[CTRL_SYNC_BIT];
          ctrl_d[wr_voice].en   = wr_data[CTRL_EN_BIT];
          ctrl_d[wr_voice].wave = wave_e'(wr_data[2:0]);
        end
        default:     duty_d[wr_voice]   = wr_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        acc_q[i]    <= '0;
        tune_q[i]   <= '0;
        shadow_q[i] <= '0;
        ctrl_q[i]   <= '0;
        duty_q[i]   <= 8'h80;
        cap_q[i]    <= '0;
      end
      div_cnt_q    <= '0;
      state_q      <= IDLE;
      vidx_q       <= '0;
      sum_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      tune_q       <= tune_d;
      shadow_q     <= shadow_d;
      ctrl_q       <= ctrl_d;
      duty_q       <= duty_d;
      cap_q        <= cap_d;
      div_cnt_q    <= div_cnt_d;
      state_q      <= state_d;
      vidx_q       <= vidx_d;
      sum_q        <= sum_d;
      lfsr_q       <= lfsr_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_sample = out_sample_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_dds_voice_bank.sv
// Directed self-checking bench for dds_voice_bank (default parameters).
module tb_dds_voice_bank;

  localparam int unsigned NV = 2;
  localparam int unsigned VW = $clog2(NV);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [VW+1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          mix_mode;
  logic [VW-1:0] out_sel;
  logic [11:0]   out_sample;
  logic          out_valid;

  int n_checks = 0;
  int n_pass   = 0;

  dds_voice_bank #(
    .NUM_VOICES(NV),
    .ACC_W(16),
    .WAVE_W(12),
    .SAMPLE_DIV(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .mix_mode   (mix_mode),
    .out_sel    (out_sel),
    .out_sample (out_sample),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) return;
    end
    n_checks = n_checks + 1;
    $error("FAIL valid_timeout: observed no out_valid expected pulse within 40 cycles");
  endtask

  task automatic write_reg(input int v, input int r, input logic [7:0] d);
    logic [VW-1:0] vb;
    logic [1:0]    rb;
    vb      = v[VW-1:0];
    rb      = r[1:0];
    wr_addr = {vb, rb};
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int pulse_edge[3];
    int np;
    logic [11:0] exp_s;

    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    mix_mode = 1'b0;
    out_sel  = '0;

    // Test 1: reset values and idle pulse cadence
    #1;
    check("rst_sample", out_sample, 12'h000);
    check("rst_valid", out_valid, 1'b0);
    do_reset();
    np = 0;
    for (int k = 1; k <= 51; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        if (np < 3) pulse_edge[np] = k;
        np = np + 1;
        check("idle_sample", out_sample, 12'h000);
      end
    end
    check("idle_pulse_count", np, 3);
    check("first_pulse_edge", pulse_edge[0], 19);
    check("second_pulse_edge", pulse_edge[1], 35);
    check("third_pulse_edge", pulse_edge[2], 51);

    // Test 2: voice0 saw, tune 0x0100, full wrap of the ramp
    mix_mode = 1'b0;
    out_sel  = '0;
    write_reg(0, 0, 8'h00);
    write_reg(0, 1, 8'h01);
    write_reg(0, 2, 8'h08);
    for (int i = 0; i < 258; i++) begin
      wait_valid();
      exp_s = 12'(i * 16);
      check("saw_ramp", out_sample, exp_s);
    end

    // Test 3: tune_lo alone is inaudible until tune_hi commits
    write_reg(0, 0, 8'h40);
    wait_valid(); check("lo_only_0", out_sample, 12'h020);
    wait_valid(); check("lo_only_1", out_sample, 12'h030);
    write_reg(0, 1, 8'h00);
    wait_valid(); check("commit_0", out_sample, 12'h040);
    wait_valid(); check("commit_1", out_sample, 12'h044);
    wait_valid(); check("commit_2", out_sample, 12'h048);

    // Test 4: average mix, then reset mid-RUN
    do_reset();
    mix_mode = 1'b1;
    write_reg(0, 2, 8'h0A);
    wait_valid(); check("mix_square_avg", out_sample, 12'h7FF);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_sample", out_sample, 12'h000);
    check("midrun_rst_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    np = 0;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) np = np + 1;
    end
    check("no_partial_valid", np, 0);
    @(posedge clk); #1;
    check("post_rst_first_valid", out_valid, 1'b1);
    check("post_rst_sample", out_sample, 12'h000);

    // Test 5: pulse wave with duty 0x40, then phase-reset strobe
    do_reset();
    mix_mode = 1'b0;
    out_sel  = '0;
    write_reg(0, 0, 8'h00);
    write_reg(0, 1, 8'h10);
    write_reg(0, 3, 8'h40);
    write_reg(0, 2, 8'h0C);
    for (int s = 0; s < 24; s++) begin
      wait_valid();
      exp_s = ((s % 16) < 4) ? 12'hFFF : 12'h000;
      check("pulse_pattern", out_sample, exp_s);
    end
    write_reg(0, 2, 8'h8C);
    wait_valid(); check("prst_consume", out_sample, 12'h000);
    for (int s = 0; s < 5; s++) begin
      wait_valid();
      exp_s = (s < 4) ? 12'hFFF : 12'h000;
      check("prst_restart", out_sample, exp_s);
    end

    // Test 6: voice1 saw with sync bit set, voice0 as master
    do_reset();
    mix_mode = 1'b0;
    out_sel  = VW'(1);
    write_reg(0, 0, 8'h00);
    write_reg(0, 1, 8'h40);
    write_reg(0, 2, 8'h08);
    write_reg(1, 0, 8'h00);
    write_reg(1, 1, 8'h10);
    write_reg(1, 2, 8'h18);
    for (int i = 0; i < 10; i++) begin
      wait_valid();
`ifdef DDS_HARD_SYNC_EN
      exp_s = 12'((i % 4) * 256);
`else
      exp_s = 12'(i * 256);
`endif
      check("sync_voice1", out_sample, exp_s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
